lva_store: RTL and testbench

//  Local variable array (LVA) storage for the bytecode core; responder side of the lvaindex/lvaop/

---
 rtl/lva_pkg.sv | 11 +
 rtl/lva_ram.sv | 29 ++
 rtl/lva_store.sv | 162 ++++++++++++++++
 tb/tb_lva_store.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lva_pkg.sv
// Shared types for the local variable array (LVA) store.
//   lva_state_t : responder FSM state encoding
//   LVA_READ / LVA_WRITE : encoding of the op request bit
package lva_pkg;

    typedef enum logic [1:0] {INIT, IDLE, ACCESS, RESPOND} lva_state_t;

    localparam logic LVA_READ  = 1'b0;
    localparam logic LVA_WRITE = 1'b1;

endpackage

// File: rtl/lva_ram.sv
// Single-port synchronous RAM backing the local variable array.
// One-cycle read latency. The array has no reset; the owner zero-fills it.
// Ports:
//   clk   in  system clock
//   we    in  write enable
//   addr  in  entry address, $clog2(LVASIZE) bits
//   wdata in  write data, LVADATA bits
//   rdata out registered read data for addr, LVADATA bits
module lva_ram #(
    parameter int LVADATA = 32,
    parameter int LVASIZE = 256
) (
    input  logic                       clk,
    input  logic                       we,
    input  logic [$clog2(LVASIZE)-1:0] addr,
    input  logic [LVADATA-1:0]         wdata,
    output logic [LVADATA-1:0]         rdata
);

    logic [LVADATA-1:0] mem [LVASIZE];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/lva_store.sv
// Local variable array responder for the bytecode core. Zero-fills the RAM after
// reset, then serves one load/store request at a time, answering with a one-cycle
// done pulse two cycles after the trigger.
// Optional feature: define LVA_BOUNDS_CHECK_EN to flag index >= LVASIZE with err
// (write suppressed, read returns 0). Without it err is 0 and the index wraps.
// Ports:
//   clk         in  system clock
//   rst_n       in  synchronous active-low reset
//   trigger     in  one-cycle request strobe
//   op          in  1 = write, 0 = read
//   index       in  8-bit entry index
//   write_value in  store data
//   read_value  out load result, valid from the done cycle, held until next read
//   done        out one-cycle completion pulse
//   ready       out idle and able to accept a trigger
//   err         out out-of-range index, pulses with done
//
// state   | meaning
// INIT    | zero-fill sweep of the RAM, triggers park in the pending slot
// IDLE    | ready; serve pending slot first, else capture a trigger
// ACCESS  | RAM write or read launch for the captured request
// RESPOND | done pulse, read data presented
module lva_store
    import lva_pkg::*;
#(
    parameter int LVADATA = 32,
    parameter int LVASIZE = 256
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               trigger,
    input  logic               op,
    input  logic [7:0]         index,
    input  logic [LVADATA-1:0] write_value,
    output logic [LVADATA-1:0] read_value,
    output logic               done,
    output logic               ready,
    output logic               err
);

    localparam int AW = $clog2(LVASIZE);

    lva_state_t         state_q;
    logic [AW-1:0]      init_addr_q;
    logic               pend_q;
    logic               pend_op_q;
    logic [7:0]         pend_index_q;
    logic [LVADATA-1:0] pend_data_q;
    logic               req_op_q;
    logic [7:0]         req_index_q;
    logic [LVADATA-1:0] req_data_q;
    logic [LVADATA-1:0] read_value_q;
    logic [LVADATA-1:0] read_value_d;
    logic               done_q;
    logic               ready_q;
    logic               req_oob;
    logic               ram_we;
    logic [AW-1:0]      ram_addr;
    logic [LVADATA-1:0] ram_wdata;
    logic [LVADATA-1:0] ram_rdata;

`ifdef LVA_BOUNDS_CHECK_EN
    logic               err_q;
    assign req_oob = (32'(req_index_q) >= LVASIZE);
    assign err     = err_q;
`else
    assign req_oob = 1'b0;
    assign err     = 1'b0;
`endif

    assign ram_we    = (state_q == INIT) ||
                       ((state_q == ACCESS) && (req_op_q == LVA_WRITE) && !req_oob);
    assign ram_addr  = (state_q == INIT) ? init_addr_q : AW'(req_index_q);
    assign ram_wdata = (state_q == INIT) ? '0 : req_data_q;

    // RAM data arrives in RESPOND; expose it straight away so it is valid with done.
    always_comb begin
        read_value_d = read_value_q;
        if ((state_q == RESPOND) && (req_op_q == LVA_READ)) begin
            read_value_d = req_oob ? '0 : ram_rdata;
        end
    end

    assign read_value = read_value_d;
    assign done       = done_q;
    assign ready      = ready_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= INIT;
            init_addr_q  <= '0;
            pend_q       <= 1'b0;
            read_value_q <= '0;
            done_q       <= 1'b0;
            ready_q      <= 1'b0;
`ifdef LVA_BOUNDS_CHECK_EN
            err_q        <= 1'b0;
`endif
        end else begin
            done_q       <= 1'b0;
            read_value_q <= read_value_d;
`ifdef LVA_BOUNDS_CHECK_EN
            err_q        <= 1'b0;
`endif
            case (state_q)
                INIT: begin
                    init_addr_q <= init_addr_q + 1'b1;
                    if (trigger) begin
                        pend_q       <= 1'b1;
                        pend_op_q    <= op;
                        pend_index_q <= index;
                        pend_data_q  <= write_value;
                    end
                    if (init_addr_q == AW'(LVASIZE - 1)) begin
                        state_q <= IDLE;
                        ready_q <= 1'b1;
                    end
                end
                IDLE: begin
                    if (pend_q) begin
                        req_op_q    <= pend_op_q;
                        req_index_q <= pend_index_q;
                        req_data_q  <= pend_data_q;
                        pend_q      <= 1'b0;
                        state_q     <= ACCESS;
                        ready_q     <= 1'b0;
                    end else if (trigger) begin
                        req_op_q    <= op;
                        req_index_q <= index;
                        req_data_q  <= write_value;
                        state_q     <= ACCESS;
                        ready_q     <= 1'b0;
                    end
                end
                ACCESS: begin
                    done_q  <= 1'b1;
`ifdef LVA_BOUNDS_CHECK_EN
                    err_q   <= req_oob;
`endif
                    state_q <= RESPOND;
                end
                RESPOND: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                end
                default: state_q <= INIT;
            endcase
        end
    end

    lva_ram #(
        .LVADATA(LVADATA),
        .LVASIZE(LVASIZE)
    ) u_ram (
        .clk  (clk),
        .we   (ram_we),
        .addr (ram_addr),
        .wdata(ram_wdata),
        .rdata(ram_rdata)
    );

endmodule

// File: tb/tb_lva_store.sv
module tb_lva_store;

    localparam int N = 16;
`ifdef LVA_BOUNDS_CHECK_EN
    localparam bit BCHK = 1'b1;
`else
    localparam bit BCHK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        trigger = 1'b0;
    logic        op = 1'b0;
    logic [7:0]  index = '0;
    logic [31:0] write_value = '0;
    logic [31:0] read_value;
    logic        done;
    logic        ready;
    logic        err;

    int checks = 0;
    int errors = 0;

    lva_store #(.LVADATA(32), .LVASIZE(N)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .trigger    (trigger),
        .op         (op),
        .index      (index),
        .write_value(write_value),
        .read_value (read_value),
        .done       (done),
        .ready      (ready),
        .err        (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        op;
        logic [7:0]  idx;
        logic [31:0] data;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    vec_t vecs[10];

    // reference model: plain array of words plus the last value presented
    logic [31:0] ref_mem [N];
    logic [31:0] ref_last;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) ref_mem[i] = '0;
        ref_last = '0;
    endtask

    task automatic model_apply(input logic o, input logic [7:0] idx, input logic [31:0] d,
                               output logic [31:0] rd, output logic er);
        er = BCHK && (int'(idx) >= N);
        if (er) begin
            rd = o ? ref_last : 32'h0;
        end else if (o) begin
            ref_mem[int'(idx) % N] = d;
            rd = ref_last;
        end else begin
            rd = ref_mem[int'(idx) % N];
        end
        ref_last = rd;
    endtask

    task automatic do_reset();
        int cnt;
        @(negedge clk);
        rst_n = 1'b0;
        trigger = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cnt = 0;
        while (!ready && cnt < N + 20) begin
            tick();
            cnt++;
        end
        chk("ready_latency", cnt, N);
    endtask

    task automatic wait_ready();
        int c;
        c = 0;
        @(negedge clk);
        while (!ready && c < 50) begin
            @(negedge clk);
            c++;
        end
        if (!ready) chk("ready_timeout", 0, 1);
    endtask

    task automatic issue(input logic o, input logic [7:0] idx, input logic [31:0] d,
                         output logic [31:0] rd, output logic er);
        logic d0, d1, d2, e2;
        logic [31:0] rv2;
        wait_ready();
        trigger = 1'b1;
        op = o;
        index = idx;
        write_value = d;
        tick();
        d0 = done;
        @(negedge clk);
        trigger = 1'b0;
        write_value = $urandom;
        tick();
        d1 = done;
        rd = read_value;
        er = err;
        tick();
        d2 = done;
        e2 = err;
        rv2 = read_value;
        chk("done_T1", 32'(d0), 0);
        chk("done_T2", 32'(d1), 1);
        chk("done_T3", 32'(d2), 0);
        chk("err_after", 32'(e2), 0);
        chk("rv_hold", rv2, rd);
    endtask

    initial begin
        logic [31:0] rd, exp_rd;
        logic        er, exp_er;
        int          dcnt;

        vecs[0] = '{1'b0, 8'd0,  32'h0,         32'h0,         1'b0};
        vecs[1] = '{1'b0, 8'd17, 32'h0,         32'h0,         BCHK};
        vecs[2] = '{1'b0, 8'd15, 32'h0,         32'h0,         1'b0};
        vecs[3] = '{1'b1, 8'd5,  32'hDEAD_BEEF, 32'h0,         1'b0};
        vecs[4] = '{1'b0, 8'd5,  32'h0,         32'hDEAD_BEEF, 1'b0};
        vecs[5] = '{1'b1, 8'd3,  32'd7,         32'hDEAD_BEEF, 1'b0};
        vecs[6] = '{1'b0, 8'd3,  32'h0,         32'd7,         1'b0};
        vecs[7] = '{1'b1, 8'd20, 32'd99,        32'd7,         BCHK};
        vecs[8] = '{1'b0, 8'd20, 32'h0,         BCHK ? 32'd0 : 32'd99, BCHK};
        vecs[9] = '{1'b0, 8'd4,  32'h0,         BCHK ? 32'd0 : 32'd99, 1'b0};

        // reset, ready timing, directed vectors
        do_reset();
        chk("reset_rv", read_value, 0);
        chk("reset_err", 32'(err), 0);
        for (int i = 0; i < 10; i++) begin
            issue(vecs[i].op, vecs[i].idx, vecs[i].data, rd, er);
            chk($sformatf("vec%0d_rd", i), rd, vecs[i].exp_rd);
            chk($sformatf("vec%0d_err", i), 32'(er), 32'(vecs[i].exp_err));
        end

        // trigger held into ACCESS must be ignored
        wait_ready();
        trigger = 1'b1; op = 1'b0; index = 8'd3;
        tick();
        @(negedge clk);
        op = 1'b1; write_value = 32'd999;
        tick();
        chk("acc_done", 32'(done), 1);
        chk("acc_rd", read_value, 32'd7);
        @(negedge clk);
        trigger = 1'b0;
        dcnt = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (done) dcnt++;
        end
        chk("acc_extra_done", dcnt, 0);
        issue(1'b0, 8'd3, 32'h0, rd, er);
        chk("acc_idx3", rd, 32'd7);

        // trigger during INIT is parked and served once
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        trigger = 1'b1; op = 1'b1; index = 8'd2; write_value = 32'h1234;
        @(negedge clk);
        trigger = 1'b0;
        dcnt = 0;
        for (int i = 0; i < N + 10; i++) begin
            tick();
            if (done) dcnt++;
        end
        chk("pend_done_cnt", dcnt, 1);
        issue(1'b0, 8'd2, 32'h0, rd, er);
        chk("pend_idx2", rd, 32'h1234);
        issue(1'b0, 8'd5, 32'h0, rd, er);
        chk("pend_rezero", rd, 32'h0);

        // reset during ACCESS of a write
        wait_ready();
        trigger = 1'b1; op = 1'b1; index = 8'd1; write_value = 32'd55;
        tick();
        @(negedge clk);
        trigger = 1'b0;
        rst_n = 1'b0;
        tick();
        chk("rst_nodone", 32'(done), 0);
        @(negedge clk);
        rst_n = 1'b1;
        dcnt = 0;
        for (int i = 0; i < N; i++) begin
            tick();
            if (done) dcnt++;
        end
        chk("rst_done_cnt", dcnt, 0);
        chk("rst_ready", 32'(ready), 1);
        chk("rst_rv", read_value, 0);
        issue(1'b0, 8'd1, 32'h0, rd, er);
        chk("rst_idx1", rd, 32'h0);

        // randomized traffic against the reference model
        do_reset();
        model_reset();
        for (int i = 0; i < 200; i++) begin
            logic        o;
            logic [7:0]  idx;
            logic [31:0] d;
            o = 1'($urandom_range(0, 1));
            idx = 8'($urandom_range(0, N + 8));
            d = $urandom;
            model_apply(o, idx, d, exp_rd, exp_er);
            issue(o, idx, d, rd, er);
            chk("rand_rd", rd, exp_rd);
            chk("rand_err", 32'(er), 32'(exp_er));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
